// File: rtl/leaf_bridge_pkg.sv
// Purpose: shared constants and helpers for the leaf stream bridge and its FIFOs.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package leaf_bridge_pkg;

  // Defaults used by the bridge and FIFO parameter lists.
  localparam int DEF_PAYLOAD_BITS = 32;
  localparam int DEF_CNT_BITS     = 32;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Ceiling log2, usable in constant expressions. Returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Purpose: generic first-word-fall-through FIFO used for every bridge channel.
// Latency: 1 cycle, a word written in cycle N is presented at the output in cycle N+1.
// Backpressure: wr_ready = !full (and low during reset); a write is refused when full even if a read happens that cycle.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset (clears pointers, discards contents)
//   wr_data/wr_valid/wr_ready   write side handshake
//   rd_data/rd_valid/rd_ready   read side handshake, rd_valid = !empty
module stream_fifo
  import leaf_bridge_pkg::*;
#(
  parameter int WIDTH = DEF_PAYLOAD_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits are equal.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready depends only on stored state and reset, never on the read side,
  // so a simultaneous pop cannot open a slot for a push in a full cycle.
  assign wr_ready = !full && !reset;
  assign push     = wr_valid && wr_ready;

  // Output valid comes from registered pointers only: no combinational path
  // from wr_valid to rd_valid.
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage is not reset; contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Purpose: buffered bridge between leaf_interface vld/ack ports and HLS kernel AXI-stream ports, one FIFO per channel.
// Latency: 1 cycle through each channel FIFO (plus run gating on kernel-bound channels).
// Backpressure: each side sees ready = !full of its FIFO; kernel-bound words are held while run_q is low.
//
// Ports:
//   clk, reset, run                         clock, sync active-high reset, kernel-feed enable
//   dout_leaf_interface2user / vld_interface2user / ack_user2interface   interface -> bridge, per input channel
//   in_tdata / in_tvalid / in_tready        bridge -> kernel Input_i streams
//   out_tdata / out_tvalid / out_tready     kernel Output_i streams -> bridge
//   din_leaf_user2interface / vld_user2interface / ack_interface2user   bridge -> interface, per output channel
//   in_count / out_count                    wrapping per-channel transfer counters
//   idle                                    registered: all FIFOs were empty last cycle
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 1,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int CNT_BITS      = DEF_CNT_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                run,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_tdata,
  output logic [NUM_IN_PORTS-1:0]               in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]               in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]              out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]              out_tready,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]      in_count,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     out_count,
  output logic                                idle
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic                     run_q;
  logic [NUM_IN_PORTS-1:0]  in_fifo_vld;   // input FIFO non-empty
  logic [NUM_IN_PORTS-1:0]  in_gate;       // channel allowed to present data
  logic [NUM_IN_PORTS-1:0]  in_pop_en;     // kernel ready, qualified by the gate
  logic [NUM_IN_PORTS-1:0]  held_q;        // word presented last cycle and not taken
  logic [NUM_IN_PORTS-1:0]  in_fire;
  logic [NUM_OUT_PORTS-1:0] out_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run;
    end
  end

  // ---------------------------------------------------------------------
  // Interface -> kernel channels
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
    logic [CNT_BITS-1:0] cnt_q;

    stream_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_data  (dout_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_valid (vld_interface2user[gi]),
      .wr_ready (ack_user2interface[gi]),
      .rd_data  (in_tdata[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_valid (in_fifo_vld[gi]),
      .rd_ready (in_pop_en[gi])
    );

    // A word already on the bus keeps its valid through a run drop, so the
    // gate stays open for that channel until the word is accepted.
    assign in_gate[gi]   = run_q || held_q[gi];
    assign in_tvalid[gi] = in_fifo_vld[gi] && in_gate[gi];
    assign in_pop_en[gi] = in_tready[gi] && in_gate[gi];
    assign in_fire[gi]   = in_tvalid[gi] && in_tready[gi];

    always_ff @(posedge clk) begin
      if (reset) begin
        held_q[gi] <= 1'b0;
        cnt_q      <= '0;
      end else begin
        held_q[gi] <= in_tvalid[gi] && !in_tready[gi];
        if (in_fire[gi]) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end

    assign in_count[gi*CNT_BITS +: CNT_BITS] = cnt_q;
  end

  // ---------------------------------------------------------------------
  // Kernel -> interface channels (not gated by run)
  // ---------------------------------------------------------------------
  for (genvar go = 0; go < NUM_OUT_PORTS; go++) begin : g_out
    logic [CNT_BITS-1:0] cnt_q;

    stream_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_data  (out_tdata[go*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_valid (out_tvalid[go]),
      .wr_ready (out_tready[go]),
      .rd_data  (din_leaf_user2interface[go*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_valid (vld_user2interface[go]),
      .rd_ready (ack_interface2user[go])
    );

    assign out_fire[go] = vld_user2interface[go] && ack_interface2user[go];

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (out_fire[go]) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end

    assign out_count[go*CNT_BITS +: CNT_BITS] = cnt_q;
  end

  // ---------------------------------------------------------------------
  // Idle: registered view of "every FIFO empty".
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      idle <= 1'b1;
    end else begin
      idle <= !(|in_fifo_vld) && !(|vld_user2interface);
    end
  end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Purpose: self-checking bench for leaf_stream_bridge with a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_leaf_stream_bridge;

  localparam int NI    = 2;
  localparam int NO    = 3;
  localparam int PB    = 32;
  localparam int DEPTH = 4;
  localparam int CB    = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic [NI*PB-1:0] dout_leaf_interface2user = '0;
  logic [NI-1:0]    vld_interface2user = '0;
  logic [NI-1:0]    ack_user2interface;
  logic [NI*PB-1:0] in_tdata;
  logic [NI-1:0]    in_tvalid;
  logic [NI-1:0]    in_tready = '0;
  logic [NO*PB-1:0] out_tdata = '0;
  logic [NO-1:0]    out_tvalid = '0;
  logic [NO-1:0]    out_tready;
  logic [NO*PB-1:0] din_leaf_user2interface;
  logic [NO-1:0]    vld_user2interface;
  logic [NO-1:0]    ack_interface2user = '0;
  logic [NI*CB-1:0] in_count;
  logic [NO*CB-1:0] out_count;
  logic             idle;

  leaf_stream_bridge #(
    .PAYLOAD_BITS  (PB),
    .NUM_IN_PORTS  (NI),
    .NUM_OUT_PORTS (NO),
    .FIFO_DEPTH    (DEPTH),
    .CNT_BITS      (CB)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .run                      (run),
    .dout_leaf_interface2user (dout_leaf_interface2user),
    .vld_interface2user       (vld_interface2user),
    .ack_user2interface       (ack_user2interface),
    .in_tdata                 (in_tdata),
    .in_tvalid                (in_tvalid),
    .in_tready                (in_tready),
    .out_tdata                (out_tdata),
    .out_tvalid               (out_tvalid),
    .out_tready               (out_tready),
    .din_leaf_user2interface  (din_leaf_user2interface),
    .vld_user2interface       (vld_user2interface),
    .ack_interface2user       (ack_interface2user),
    .in_count                 (in_count),
    .out_count                (out_count),
    .idle                     (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words accepted by the bridge but not yet delivered,
  // per channel, in order. Queue length is the channel occupancy.
  logic [PB-1:0] q_in  [NI][$];
  logic [PB-1:0] q_out [NO][$];
  int cnt_in  [NI];
  int cnt_out [NO];
  bit stall_in  [NI];
  bit stall_out [NO];
  bit run_q_m;
  bit prev_empty;
  bit all_empty;
  int occ;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Monitor: observes the DUT half a cycle before each rising edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_ack", 0, 64'(ack_user2interface), 64'(0));
      chk("reset_out_tready", 0, 64'(out_tready), 64'(0));
      for (int i = 0; i < NI; i++) begin
        q_in[i].delete();
        cnt_in[i]   = 0;
        stall_in[i] = 1'b0;
      end
      for (int j = 0; j < NO; j++) begin
        q_out[j].delete();
        cnt_out[j]   = 0;
        stall_out[j] = 1'b0;
      end
      run_q_m    = 1'b0;
      prev_empty = 1'b1;
    end else begin
      chk("idle", 0, 64'(idle), 64'(prev_empty));
      all_empty = 1'b1;
      for (int i = 0; i < NI; i++) begin
        occ = q_in[i].size();
        if (occ != 0) all_empty = 1'b0;
        chk("ack_user2interface", i, 64'(ack_user2interface[i]), 64'(occ < DEPTH));
        chk("in_tvalid", i, 64'(in_tvalid[i]), 64'((occ > 0) && (run_q_m || stall_in[i])));
        chk("in_count", i, 64'(in_count[i*CB +: CB]), 64'(cnt_in[i] % (1 << CB)));
        if (in_tvalid[i] && occ > 0) begin
          chk("in_tdata", i, 64'(in_tdata[i*PB +: PB]), 64'(q_in[i][0]));
          if (in_tready[i]) begin
            void'(q_in[i].pop_front());
            cnt_in[i]++;
          end
        end
        stall_in[i] = in_tvalid[i] && !in_tready[i];
      end
      for (int j = 0; j < NO; j++) begin
        occ = q_out[j].size();
        if (occ != 0) all_empty = 1'b0;
        chk("out_tready", j, 64'(out_tready[j]), 64'(occ < DEPTH));
        chk("vld_user2interface", j, 64'(vld_user2interface[j]), 64'(occ > 0));
        chk("out_count", j, 64'(out_count[j*CB +: CB]), 64'(cnt_out[j] % (1 << CB)));
        if (vld_user2interface[j] && occ > 0) begin
          chk("din_leaf_user2interface", j, 64'(din_leaf_user2interface[j*PB +: PB]), 64'(q_out[j][0]));
          if (ack_interface2user[j]) begin
            void'(q_out[j].pop_front());
            cnt_out[j]++;
          end
        end
        stall_out[j] = vld_user2interface[j] && !ack_interface2user[j];
      end
      prev_empty = all_empty;
      run_q_m    = run;
    end
  end

  // Stimulus state.
  bit [PB-1:0] in_word  [NI];
  bit [PB-1:0] out_word [NO];
  bit in_pend  [NI];
  bit out_pend [NO];
  int in_left  [NI];
  int out_left [NO];
  int p_in_vld  = 100;
  int p_tready  = 100;
  int p_out_vld = 100;
  int p_ack     = 100;
  bit run_rand  = 1'b0;
  bit [NI-1:0] acc_in;
  bit [NO-1:0] acc_out;

  // One clock cycle: note which words will be accepted at the coming edge,
  // then after the edge record them as expected and drive new stimulus.
  task automatic step();
    @(negedge clk);
    acc_in  = vld_interface2user & ack_user2interface;
    acc_out = out_tvalid & out_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (acc_in[i]) begin
        q_in[i].push_back(in_word[i]);
        in_pend[i] = 1'b0;
      end
      if (!in_pend[i] && in_left[i] > 0 && $urandom_range(99) < p_in_vld) begin
        in_word[i] = $urandom;
        in_pend[i] = 1'b1;
        in_left[i]--;
      end
      vld_interface2user[i] = in_pend[i];
      dout_leaf_interface2user[i*PB +: PB] = in_word[i];
      in_tready[i] = ($urandom_range(99) < p_tready);
    end
    for (int j = 0; j < NO; j++) begin
      if (acc_out[j]) begin
        q_out[j].push_back(out_word[j]);
        out_pend[j] = 1'b0;
      end
      if (!out_pend[j] && out_left[j] > 0 && $urandom_range(99) < p_out_vld) begin
        out_word[j] = $urandom;
        out_pend[j] = 1'b1;
        out_left[j]--;
      end
      out_tvalid[j] = out_pend[j];
      out_tdata[j*PB +: PB] = out_word[j];
      ack_interface2user[j] = ($urandom_range(99) < p_ack);
    end
    if (run_rand && $urandom_range(99) < 3) run = !run;
  endtask

  function automatic bit all_done();
    bit d;
    d = 1'b1;
    for (int i = 0; i < NI; i++)
      if (in_left[i] != 0 || in_pend[i] || q_in[i].size() != 0) d = 1'b0;
    for (int j = 0; j < NO; j++)
      if (out_left[j] != 0 || out_pend[j] || q_out[j].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!all_done() && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (!all_done()) begin
      errors++;
      $display("FAIL drain_%s still busy after %0d cycles, required all words delivered", name, n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      in_pend[i] = 1'b0; in_left[i] = 0; in_word[i] = '0;
    end
    for (int j = 0; j < NO; j++) begin
      out_pend[j] = 1'b0; out_left[j] = 0; out_word[j] = '0;
    end
    do_reset();
    repeat (3) step();

    // Single word straight through.
    run = 1'b1;
    in_left[0] = 1;
    drain("single", 50);

    // Backpressure: kernel stalled, 6 words offered, FIFO holds 4.
    p_tready = 0;
    in_left[0] = 6;
    repeat (12) step();
    p_tready = 100;
    drain("backpressure", 100);

    // Run gating: words load but are not presented until run returns.
    run = 1'b0;
    in_left[0] = 3;
    repeat (10) step();
    run = 1'b1;
    drain("run_gate", 50);

    // Occupancy 2 with a push and a pop every cycle.
    p_ack = 0;
    out_left[0] = 2;
    repeat (5) step();
    p_ack = 100;
    out_left[0] = 50;
    drain("occ2", 200);

    // Full FIFO with a pop in the same cycle: the push must still be refused.
    p_ack = 0;
    out_left[0] = 6;
    repeat (10) step();
    p_ack = 100;
    drain("full_pop", 100);

    // Randomized multichannel traffic from a clean counter state.
    do_reset();
    run_rand  = 1'b1;
    p_in_vld  = 70;
    p_tready  = 60;
    p_out_vld = 70;
    p_ack     = 60;
    for (int i = 0; i < NI; i++) in_left[i] = 300;
    for (int j = 0; j < NO; j++) out_left[j] = 1000;
    drain("random", 20000);
    run_rand = 1'b0;
    run = 1'b1;
    step();
    for (int j = 0; j < NO; j++)
      chk("out_count_1000", j, 64'(out_count[j*CB +: CB]), 64'(1000 % 256));

    // Reset mid-stream with buffered words and non-zero counters.
    do_reset();
    p_in_vld = 100; p_tready = 100; p_out_vld = 100; p_ack = 100;
    in_left[0] = 17;
    out_left[0] = 17;
    drain("pre_reset", 200);
    chk("in_count_17", 0, 64'(in_count[CB-1:0]), 64'(17));
    chk("out_count_17", 0, 64'(out_count[CB-1:0]), 64'(17));
    p_tready = 0;
    p_ack    = 0;
    in_left[0]  = 3;
    out_left[0] = 3;
    repeat (6) step();
    do_reset();
    step();
    chk("post_reset_idle", 0, 64'(idle), 64'(1));
    chk("post_reset_in_tvalid", 0, 64'(in_tvalid), 64'(0));
    chk("post_reset_vld_user2interface", 0, 64'(vld_user2interface), 64'(0));
    chk("post_reset_in_count", 0, 64'(in_count), 64'(0));
    chk("post_reset_out_count", 0, 64'(out_count), 64'(0));
    p_tready = 100;
    p_ack    = 100;
    in_left[0]  = 5;
    out_left[0] = 5;
    drain("post_reset", 100);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
